// File: rtl/ltl_mon_pkg.sv
// ltl_mon_pkg -- shared types for the LTL monitor engine.
//
// Contents:
//   start_e      start type of an STE (none / start-of-data / all-input)
//   cfg_sel_e    configuration write target selector
//   interval_t   one match interval {lo, hi, valid}, sized for the widest symbol
//   unpack_interval()  extracts an interval from a 32-bit config word
package ltl_mon_pkg;

  // Widest supported symbol; narrower symbols are zero-extended for compares.
  localparam int SYM_W_MAX = 15;

  typedef enum logic [1:0] {
    START_NONE = 2'd0,
    START_SOD  = 2'd1,
    START_ALL  = 2'd2,
    START_RSVD = 2'd3   // behaves as START_NONE
  } start_e;

  typedef enum logic [1:0] {
    SEL_INTERVAL = 2'd0,
    SEL_ADJ      = 2'd1,
    SEL_START    = 2'd2,
    SEL_MASK     = 2'd3
  } cfg_sel_e;

  typedef struct packed {
    logic [SYM_W_MAX-1:0] lo;
    logic [SYM_W_MAX-1:0] hi;
    logic                 valid;
  } interval_t;

  // lo sits in data[sym_w-1:0], hi in data[2*sym_w-1:sym_w], valid in data[31].
  function automatic interval_t unpack_interval(input logic [31:0] data, input int sym_w);
    interval_t r;
    r = '0;
    for (int k = 0; k < SYM_W_MAX; k++) begin
      if (k < sym_w) begin
        r.lo[k] = data[k];
        r.hi[k] = data[sym_w + k];
      end
    end
    r.valid = data[31];
    return r;
  endfunction

endpackage

// File: rtl/ltl_mon_interval_match.sv
// ltl_mon_interval_match -- per-STE symbol class test.
//
// Ports:
//   intervals  N_INT configured intervals of this STE
//   symbols    current input symbol (SYM_W bits, unsigned)
//   match      1 when any valid interval contains the symbol (inclusive bounds)
module ltl_mon_interval_match
  import ltl_mon_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int N_INT = 4
) (
  input  interval_t [N_INT-1:0] intervals,
  input  logic [SYM_W-1:0]      symbols,
  output logic                  match
);

  logic [SYM_W_MAX-1:0] sym_ext;
  logic [N_INT-1:0]     hit;

  assign sym_ext = SYM_W_MAX'(symbols);

  for (genvar k = 0; k < N_INT; k++) begin : g_cmp
    assign hit[k] = intervals[k].valid
                  && (intervals[k].lo <= sym_ext)
                  && (sym_ext <= intervals[k].hi);
  end

  assign match = |hit;

endmodule

// File: rtl/ltl_mon_engine.sv
// ltl_mon_engine -- homogeneous-automaton monitor with a single-entry report buffer.
//
// Each STE (state transition element) activates when its symbol class matches
// and it is either enabled by an active predecessor or by its start type.
// Reports (active & mask) are held until the consumer takes them; a report
// arriving while one is held and not being accepted is dropped and flagged.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   run, symbols      symbol-valid strobe and symbol
//   cfg_we/sel/idx/sub/data  configuration write port (accepted only when run=0)
//   cfg_err           sticky: an illegal config write was seen
//   active            registered active-state vector
//   rpt_valid/ready   report handshake
//   rpt_vec, rpt_ts   held report vector and its run-cycle index
//   rpt_ovf           sticky: a report was dropped
//   hit_cnt           (LTL_MON_HIT_CNT_EN only) saturating count of accepted reports
//
// Build option: define LTL_MON_HIT_CNT_EN to add the hit_cnt output.
module ltl_mon_engine
  import ltl_mon_pkg::*;
#(
  parameter int N_STE = 16,
  parameter int SYM_W = 8,
  parameter int N_INT = 4,
  parameter int TS_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [SYM_W-1:0] symbols,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [4:0]       cfg_idx,
  input  logic [2:0]       cfg_sub,
  input  logic [31:0]      cfg_data,
  output logic             cfg_err,
  output logic [N_STE-1:0] active,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [N_STE-1:0] rpt_vec,
  output logic [TS_W-1:0]  rpt_ts,
  output logic             rpt_ovf
`ifdef LTL_MON_HIT_CNT_EN
  ,
  output logic [15:0]      hit_cnt
`endif
);

  // ---------------------------------------------------------------- config
  interval_t [N_INT-1:0] ivl_tab   [N_STE];
  logic [N_STE-1:0]      adj_tab   [N_STE];
  start_e                start_tab [N_STE];
  logic [N_STE-1:0]      rpt_mask;

  cfg_sel_e sel;
  logic     cfg_bad;
  logic     cfg_ok;

  assign sel     = cfg_sel_e'(cfg_sel);
  assign cfg_bad = cfg_we && (run || (int'(cfg_idx) >= N_STE) || (int'(cfg_sub) >= N_INT));
  assign cfg_ok  = cfg_we && !cfg_bad;

  // Only the low bits of cfg_data are meaningful for narrow configurations.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^cfg_data;

  // NOTE: the config tables are flops with reset, not a RAM: every output must
  // read 0 after reset, so stale match rules must not survive it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_STE; i++) begin
        ivl_tab[i]   <= '0;
        adj_tab[i]   <= '0;
        start_tab[i] <= START_NONE;
      end
      rpt_mask <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (cfg_bad) cfg_err <= 1'b1;
      if (cfg_ok) begin
        // Decode by comparison so a 5-bit index never aliases a narrower table.
        for (int i = 0; i < N_STE; i++) begin
          if (int'(cfg_idx) == i) begin
            case (sel)
              SEL_INTERVAL: begin
                for (int k = 0; k < N_INT; k++) begin
                  if (int'(cfg_sub) == k) ivl_tab[i][k] <= unpack_interval(cfg_data, SYM_W);
                end
              end
              SEL_ADJ:   adj_tab[i]   <= cfg_data[N_STE-1:0];
              SEL_START: start_tab[i] <= start_e'(cfg_data[1:0]);
              default: ;
            endcase
          end
        end
        if (sel == SEL_MASK) rpt_mask <= cfg_data[N_STE-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- matching
  logic [N_STE-1:0] match;

  for (genvar i = 0; i < N_STE; i++) begin : g_ste
    ltl_mon_interval_match #(
      .SYM_W (SYM_W),
      .N_INT (N_INT)
    ) u_match (
      .intervals (ivl_tab[i]),
      .symbols   (symbols),
      .match     (match[i])
    );
  end

  // ---------------------------------------------------------------- next state
  logic             armed;   // cleared by the first run cycle after reset
  logic             sod;
  logic [TS_W-1:0]  ts;
  logic [N_STE-1:0] active_next;
  logic [N_STE-1:0] rep;
  logic             rep_fire;

  assign sod = armed && run;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    active_next = '0;
    for (int i = 0; i < N_STE; i++) begin
      active_next[i] = match[i]
                     && ((|(active & adj_tab[i]))
                         || (start_tab[i] == START_ALL)
                         || ((start_tab[i] == START_SOD) && sod));
    end
  end

  assign rep      = active_next & rpt_mask;
  assign rep_fire = run && (|rep);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active <= '0;
      ts     <= '0;
      armed  <= 1'b1;
    end else if (run) begin
      active <= active_next;
      ts     <= ts + TS_W'(1);
      armed  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- report buffer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_valid <= 1'b0;
      rpt_vec   <= '0;
      rpt_ts    <= '0;
      rpt_ovf   <= 1'b0;
    end else begin
      if (rep_fire && (!rpt_valid || rpt_ready)) begin
        // Empty slot, or the held report leaves this cycle: take the new one.
        rpt_valid <= 1'b1;
        rpt_vec   <= rep;
        rpt_ts    <= ts;
      end else if (rpt_valid && rpt_ready) begin
        rpt_valid <= 1'b0;
      end else if (rep_fire) begin
        // Slot occupied and not draining: the new report is lost.
        rpt_ovf <= 1'b1;
      end
    end
  end

`ifdef LTL_MON_HIT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt <= '0;
    end else if (rpt_valid && rpt_ready && (hit_cnt != 16'hFFFF)) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ltl_mon_engine.md
LTL_MON_ENGINE -- requirements
Module: ltl_mon_engine

Interface
REQ-001 SHALL have parameter N_STE, default 16, number of STEs (2..32).
REQ-002 SHALL have parameter SYM_W, default 8, symbol width (1..15).
REQ-003 SHALL have parameter N_INT, default 4, match intervals per STE (1..8).
REQ-004 SHALL have parameter TS_W, default 32, report timestamp width.
REQ-005 SHALL have port clk, input, 1, the single clock; all flops rise on posedge clk.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port run, input, 1, symbol-valid/advance enable.
REQ-008 SHALL have port symbols, input, SYM_W, current input symbol.
REQ-009 SHALL have port cfg_we, input, 1, configuration write strobe.
REQ-010 SHALL have port cfg_sel, input, 2, target: 0 interval, 1 adjacency row, 2 start type, 3 report mask.
REQ-011 SHALL have port cfg_idx, input, 5, STE index.
REQ-012 SHALL have port cfg_sub, input, 3, interval index.
REQ-013 SHALL have port cfg_data, input, 32, write data.
REQ-014 SHALL have port cfg_err, output, 1, sticky flag for an illegal config write.
REQ-015 SHALL have port active, output, N_STE, registered active-state vector.
REQ-016 SHALL have port rpt_valid, output, 1, report held.
REQ-017 SHALL have port rpt_ready, input, 1, consumer accepts the report.
REQ-018 SHALL have port rpt_vec, output, N_STE, held report vector.
REQ-019 SHALL have port rpt_ts, output, TS_W, run-cycle index of the held report.
REQ-020 SHALL have port rpt_ovf, output, 1, sticky flag for a dropped report.

Function
REQ-021 SHALL define interval config data as: lo = cfg_data[SYM_W-1:0], hi = cfg_data[2*SYM_W-1:SYM_W], valid = cfg_data[31]; STE i matches when any valid interval has lo <= symbols <= hi (inclusive, unsigned).
REQ-022 SHALL use cfg_data[N_STE-1:0] as the adjacency row, where bit j set means an edge from STE j into STE cfg_idx; self-loops are legal.
REQ-023 SHALL use cfg_data[1:0] as start type: 0 none, 1 start-of-data, 2 all-input (3 reserved, treated as none).
REQ-024 SHALL use cfg_data[N_STE-1:0] as the report mask.
REQ-025 SHALL accept config writes only when run=0; a write with run=1, cfg_idx>=N_STE, or cfg_sub>=N_INT is ignored and sets cfg_err.
REQ-026 SHALL assert sod for exactly the first run=1 cycle after reset deassertion, and never again until the next reset.
REQ-027 SHALL, on run=1: active_next[i] = match[i] & ( |(active & adj[i]) | start==ALL | (start==SOD & sod) ).
REQ-028 SHALL hold active and the timestamp when run=0.
REQ-029 SHALL use a timestamp counter of TS_W bits that increments on every run=1 cycle and wraps modulo 2^TS_W; the sod cycle is 0.
REQ-030 SHALL compute the report as rep = active_next & rpt_mask, evaluated on run=1 cycles, where the timestamp is the value in that cycle.
REQ-031 SHALL, if rep != 0 and no report is held, load rpt_vec/rpt_ts and set rpt_valid the next cycle.
REQ-032 SHALL clear rpt_valid on rpt_valid & rpt_ready, unless a simultaneous nonzero rep occurs, in which case the new report is loaded and rpt_valid stays 1.
REQ-033 SHALL, on a nonzero rep while rpt_valid=1 and rpt_ready=0, drop the new report, set rpt_ovf, and leave the held report unchanged.
REQ-034 SHALL keep rpt_vec/rpt_ts stable while rpt_valid=1 and rpt_ready=0.

Reset
REQ-035 SHALL, on reset, asynchronously clear: active, rpt_valid, rpt_vec, rpt_ts, rpt_ovf, cfg_err, timestamp, and the sod-armed flag (armed=1).
REQ-036 SHALL also clear config tables on reset (intervals invalid, adj 0, start none, mask 0), so every output is 0 after reset.
REQ-037 SHALL, on reset asserted mid-run, drop any held report without signalling overflow.

Configuration
REQ-038 SHALL, with LTL_MON_HIT_CNT_EN defined, add output hit_cnt (16 bits) counting accepted reports, saturating at 0xFFFF and cleared by reset.
REQ-039 SHALL, without LTL_MON_HIT_CNT_EN, have no hit_cnt port or logic.

Structure
REQ-040 SHALL place the start-type enum, the cfg_sel enum and the interval struct {lo, hi, valid} in package ltl_mon_pkg.
REQ-041 SHALL implement per-STE interval matching in sub-module ltl_mon_interval_match (N_INT comparators, OR-reduced), instantiated N_STE times.

Verification
REQ-042 SHALL cover: STE0 SOD, interval [0,7], self-loop; STE1 adj from 0, interval [8,15], report; symbols 3,5,9 -> rpt_valid with rpt_vec=0x2, rpt_ts=2.
REQ-043 SHALL cover: same config, first symbol 20 -> active stays 0 forever; no SOD re-fire on a later symbol 3.
REQ-044 SHALL cover: report held with rpt_ready=0 and a second nonzero rep -> rpt_ovf=1, rpt_ts unchanged; then rpt_ready=1 with simultaneous rep -> new report loaded, rpt_valid stays 1.
REQ-045 SHALL cover: config write with run=1, or cfg_idx=N_STE -> tables unchanged, cfg_err=1.
REQ-046 SHALL cover: TS_W=4, 17 run cycles with an all-input reporting STE matching all symbols -> last rpt_ts=0 (wrap).
REQ-047 SHALL cover: reset asserted mid-report -> all outputs 0 immediately (asynchronous), rpt_ovf=0.
